// File: rtl/piso_pkg.sv
// Shared definitions for the SIPO/PISO packer pair: default geometry and the unpacker FSM state.
package piso_pkg;

    localparam int unsigned SIZE_OF_OUTPUT_DEF = 64;
    localparam int unsigned SIZE_OF_BUFFER_DEF = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } piso_state_t;

endpackage

// File: rtl/piso.sv
// Parallel-in serial-out unpacker: loads SIZE_OF_BUFFER slices at once and emits them LSB slice first.
module piso
    import piso_pkg::*;
#(
    parameter int unsigned SIZE_OF_OUTPUT = SIZE_OF_OUTPUT_DEF,
    parameter int unsigned SIZE_OF_BUFFER = SIZE_OF_BUFFER_DEF
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 wr_en_i,
    input  logic [SIZE_OF_OUTPUT*SIZE_OF_BUFFER-1:0] data_i,
    input  logic                                 rd_en_i,
    output logic [SIZE_OF_OUTPUT-1:0]            data_o,
    output logic                                 valid_o,
    output logic                                 ready_o,
    output logic                                 is_empty_o,
    output logic                                 is_full_o,
    output logic [3:0]                           count_o
);

    localparam int unsigned TOTAL_W  = SIZE_OF_OUTPUT * SIZE_OF_BUFFER;
    localparam logic [3:0]  FULL_CNT = 4'(SIZE_OF_BUFFER);

    piso_state_t        state_q, state_d;
    logic [3:0]         count_q, count_d;
    logic [TOTAL_W-1:0] shift_q, shift_d;
    logic               last_pop;

    // Down-count that holds at zero instead of wrapping.
    function automatic logic [3:0] cnt_dec(input logic [3:0] c);
        return (c == 4'd0) ? 4'd0 : c - 4'd1;
    endfunction

    assign last_pop = (count_q == 4'd1) && rd_en_i;
    assign ready_o  = (count_q == 4'd0) || last_pop;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        unique case (state_q)
            EMPTY: begin
                if (wr_en_i) begin
                    shift_d = data_i;
                    count_d = FULL_CNT;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_en_i) begin
                    // Popping the last word frees the register for a same-cycle load.
                    if (last_pop && wr_en_i) begin
                        shift_d = data_i;
                        count_d = FULL_CNT;
                    end else begin
                        shift_d = shift_q >> SIZE_OF_OUTPUT;
                        count_d = cnt_dec(count_q);
                        if (count_q == 4'd1) begin
                            state_d = EMPTY;
                        end
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
            count_q <= 4'd0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

    assign data_o     = shift_q[SIZE_OF_OUTPUT-1:0];
    assign valid_o    = (count_q != 4'd0);
    assign is_empty_o = (count_q == 4'd0);
    assign is_full_o  = (count_q == FULL_CNT);
    assign count_o    = count_q;

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: reset, drain order, back-to-back reload, busy-load rejection, async reset, round trip.
module tb_piso;

    localparam int unsigned SOO = 64;
    localparam int unsigned SOB = 8;

    logic             clk_i;
    logic             rst_i;
    logic             wr_en_i;
    logic [SOO*SOB-1:0] data_i;
    logic             rd_en_i;
    logic [SOO-1:0]   data_o;
    logic             valid_o;
    logic             ready_o;
    logic             is_empty_o;
    logic             is_full_o;
    logic [3:0]       count_o;

    int n_chk = 0;
    int n_err = 0;

    piso #(
        .SIZE_OF_OUTPUT(SOO),
        .SIZE_OF_BUFFER(SOB)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en_i),
        .data_i    (data_i),
        .rd_en_i   (rd_en_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_o   (ready_o),
        .is_empty_o(is_empty_o),
        .is_full_o (is_full_o),
        .count_o   (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [SOO*SOB-1:0] pack_seq(input logic [63:0] base);
        logic [SOO*SOB-1:0] v;
        v = '0;
        for (int k = 0; k < SOB; k++) v[k*SOO +: SOO] = base + 64'(k);
        return v;
    endfunction

    task automatic load(input logic [SOO*SOB-1:0] d);
        data_i  = d;
        wr_en_i = 1'b1;
        cyc();
        wr_en_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"},  data_o, 64'h0);
        chk({tag, "_valid"}, 64'(valid_o), 64'h0);
        chk({tag, "_empty"}, 64'(is_empty_o), 64'h1);
        chk({tag, "_full"},  64'(is_full_o), 64'h0);
        chk({tag, "_ready"}, 64'(ready_o), 64'h1);
        chk({tag, "_count"}, 64'(count_o), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [63:0] words [SOB];
    logic [SOO*SOB-1:0] rt;

    initial begin
        rst_i   = 1'b0;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        data_i  = '0;

        // Reset held for three cycles.
        repeat (3) cyc();
        chk_reset_vals("rst");
        rst_i = 1'b1;
        cyc();

        // Plain load and full drain of slices 0..7.
        load(pack_seq(64'h0));
        chk("ld_count", 64'(count_o), 64'd8);
        chk("ld_full",  64'(is_full_o), 64'h1);
        chk("ld_valid", 64'(valid_o), 64'h1);
        for (int k = 0; k < SOB; k++) begin
            chk($sformatf("drain_d%0d", k), data_o, 64'(k));
            rd_en_i = 1'b1;
            #1;
            chk($sformatf("drain_rdy%0d", k), 64'(ready_o), (k == SOB-1) ? 64'h1 : 64'h0);
            cyc();
            if (k == 0) chk("drain_full_off", 64'(is_full_o), 64'h0);
        end
        rd_en_i = 1'b0;
        chk("drain_empty", 64'(is_empty_o), 64'h1);
        chk("drain_valid", 64'(valid_o), 64'h0);
        chk("drain_zero",  data_o, 64'h0);

        // Busy load rejected at count 5, then back-to-back reload at count 1.
        load(pack_seq(64'h0));
        rd_en_i = 1'b1;
        repeat (3) cyc();
        rd_en_i = 1'b0;
        chk("busy_cnt_pre", 64'(count_o), 64'd5);
        load({(SOO*SOB){1'b1}});
        chk("busy_cnt", 64'(count_o), 64'd5);
        chk("busy_data", data_o, 64'h3);
        for (int k = 3; k < 7; k++) begin
            chk($sformatf("busy_d%0d", k), data_o, 64'(k));
            rd_en_i = 1'b1;
            cyc();
        end
        chk("b2b_cnt1", 64'(count_o), 64'd1);
        chk("b2b_last", data_o, 64'h7);
        data_i  = pack_seq(64'h10);
        wr_en_i = 1'b1;
        cyc();
        wr_en_i = 1'b0;
        chk("b2b_cnt", 64'(count_o), 64'd8);
        chk("b2b_data", data_o, 64'h10);
        for (int k = 0; k < SOB; k++) begin
            chk($sformatf("b2b_v%0d", k), 64'(valid_o), 64'h1);
            chk($sformatf("b2b_d%0d", k), data_o, 64'h10 + 64'(k));
            cyc();
        end
        rd_en_i = 1'b0;
        chk("b2b_empty", 64'(is_empty_o), 64'h1);

        // Pops while empty must not underflow.
        rd_en_i = 1'b1;
        repeat (2) cyc();
        rd_en_i = 1'b0;
        chk("uf_count", 64'(count_o), 64'd0);
        chk("uf_valid", 64'(valid_o), 64'h0);

        // Asynchronous reset mid-drain, then a fresh load.
        load(pack_seq(64'h20));
        rd_en_i = 1'b1;
        repeat (4) cyc();
        rd_en_i = 1'b0;
        chk("ar_cnt_pre", 64'(count_o), 64'd4);
        chk("ar_dat_pre", data_o, 64'h24);
        #1 rst_i = 1'b0;
        #1;
        chk_reset_vals("arst");
        cyc();
        rst_i = 1'b1;
        cyc();
        load(pack_seq(64'h30));
        chk("fresh_cnt", 64'(count_o), 64'd8);
        chk("fresh_d0", data_o, 64'h30);
        rd_en_i = 1'b1;
        cyc();
        rd_en_i = 1'b0;
        chk("fresh_d1", data_o, 64'h31);
        rd_en_i = 1'b1;
        repeat (7) cyc();
        rd_en_i = 1'b0;
        chk("fresh_empty", 64'(is_empty_o), 64'h1);

        // Round trip: words packed in write order must emerge in the same order.
        rt = '0;
        for (int k = 0; k < SOB; k++) begin
            words[k] = {$urandom(), $urandom()};
            rt[k*SOO +: SOO] = words[k];
        end
        load(rt);
        for (int k = 0; k < SOB; k++) begin
            chk($sformatf("rt_d%0d", k), data_o, words[k]);
            rd_en_i = 1'b1;
            cyc();
        end
        rd_en_i = 1'b0;
        chk("rt_empty", 64'(is_empty_o), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
